// File: rtl/azpr_uart_rx_if.sv
// Receive-side bundle of the AZPR UART: serial line in,
// busy/strobe/byte out.
interface azpr_uart_rx_if;
  logic       rx;
  logic       rx_busy;
  logic       rx_end;
  logic [7:0] rx_data;

  modport master (
    output rx,
    input  rx_busy,
    input  rx_end,
    input  rx_data
  );

  modport slave (
    input  rx,
    output rx_busy,
    output rx_end,
    output rx_data
  );
endinterface

// File: rtl/azpr_uart_rx.sv
// AZPR UART receiver, 8N1, LSB first, centre-sampled bits.
// rx_end strobes for one cycle as rx_busy falls on a good stop bit.
module azpr_uart_rx #(
  parameter int DIV_RATE  = 260,
  parameter int DIV_CNT_W = 9
) (
  input  logic           clk,
  input  logic           reset,
  azpr_uart_rx_if.slave  bus
);

  typedef enum logic {
    IDLE,
    RX
  } state_e;

  localparam logic [DIV_CNT_W-1:0] DIV_HALF =
    DIV_CNT_W'(DIV_RATE / 2);
  localparam logic [DIV_CNT_W-1:0] DIV_FULL =
    DIV_CNT_W'(DIV_RATE - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_ONE  =
    DIV_CNT_W'(1);
  localparam logic [3:0] BIT_START = 4'd0;
  localparam logic [3:0] BIT_STOP  = 4'd9;

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 rx_s;
  state_e               state_q;
  logic [DIV_CNT_W-1:0] div_q;
  logic [3:0]           bit_q;
  logic                 busy_q;
  logic                 end_q;
  logic [7:0]           data_q;

  // Two-flop synchroniser; idles high so reset looks like a quiet line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= BIT_START;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      end_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= RX;
            busy_q  <= 1'b1;
            div_q   <= DIV_HALF;
            bit_q   <= BIT_START;
          end
        end
        RX: begin
          if (div_q != '0) begin
            div_q <= div_q - DIV_ONE;
          end else begin
            unique case (1'b1)
              (bit_q == BIT_START): begin
                if (!rx_s) begin
                  bit_q <= 4'd1;
                  div_q <= DIV_FULL;
                end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
              (bit_q == BIT_STOP): begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                end_q   <= rx_s;
              end
              (bit_q != BIT_START &&
               bit_q != BIT_STOP): begin
                data_q <= {rx_s, data_q[7:1]};
                bit_q  <= bit_q + 4'd1;
                div_q  <= DIV_FULL;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.rx_busy = busy_q;
  assign bus.rx_end  = end_q;
  assign bus.rx_data = data_q;

endmodule

// File: tb/tb_azpr_uart_rx.sv
// Bench for azpr_uart_rx: frame-level timing model plus
// literal spot checks of received bytes.
`timescale 1ns/1ps
module tb_azpr_uart_rx;

  localparam int DIV = 16;
  // start edge -> rx_end: 2 sync + 1 IDLE->RX + half bit + 9 bits
  localparam int LAT = 3 + DIV / 2 + 1 + 9 * DIV;

  typedef struct {
    int         b0;
    int         b1;
    bit         has_end;
    bit         full;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   rise_cyc;
  int   last_s;
  logic prev_busy;
  logic [7:0] base;
  ev_t  evq[$];
  logic [7:0] ends[$];

  azpr_uart_rx_if bus ();

  azpr_uart_rx #(
    .DIV_RATE  (DIV),
    .DIV_CNT_W (5)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge clk) begin
    logic eb;
    logic ee;
    logic [7:0] md;
    if (!rst_n) begin
      chk("rst_busy", int'(bus.rx_busy), 0);
      chk("rst_end", int'(bus.rx_end), 0);
      chk("rst_data", int'(bus.rx_data), 0);
    end else begin
      eb = 1'b0;
      ee = 1'b0;
      md = base;
      foreach (evq[i]) begin
        if (cyc >= evq[i].b0 && cyc < evq[i].b1) eb = 1'b1;
        if (evq[i].has_end && cyc == evq[i].b1) ee = 1'b1;
        if (evq[i].full && cyc >= evq[i].b1) md = evq[i].data;
      end
      chk("busy", int'(bus.rx_busy), int'(eb));
      chk("end", int'(bus.rx_end), int'(ee));
      if (!eb) chk("data", int'(bus.rx_data), int'(md));
      if (bus.rx_end) ends.push_back(bus.rx_data);
      if (bus.rx_busy && !prev_busy) rise_cyc = cyc;
    end
    prev_busy = bus.rx_busy;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Must be called 1 ns after a rising edge.
  task automatic send(input logic [7:0] b, input bit stop);
    int s;
    logic [9:0] fr;
    s = cyc;
    last_s = s;
    evq.push_back('{s + 3, s + LAT, stop, 1'b1, b});
    // A low stop bit is still low when IDLE looks again: short false start
    if (!stop)
      evq.push_back('{s + LAT + 1, s + LAT + DIV / 2 + 2,
                      1'b0, 1'b0, 8'h00});
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = fr[i];
      idle(DIV);
    end
    bus.rx = 1'b1;
  endtask

  initial begin
    int s;
    logic [7:0] pb;
    checks    = 0;
    errors    = 0;
    rise_cyc  = -1;
    prev_busy = 1'b0;
    base      = 8'h00;
    rst_n     = 1'b0;
    bus.rx    = 1'b1;

    repeat (10) begin
      @(posedge clk);
      #1 bus.rx = ~bus.rx;
    end
    bus.rx = 1'b1;
    idle(1);
    rst_n = 1'b1;
    idle(5);
    chk("idle_data", int'(bus.rx_data), 8'h00);
    chk("idle_busy", int'(bus.rx_busy), 0);

    ends.delete();
    send(8'h41, 1'b1);
    chk("A_rise", rise_cyc - last_s, 3);
    idle(20);
    chk("A_count", ends.size(), 1);
    if (ends.size() > 0) chk("A_byte", int'(ends[0]), 8'h41);

    ends.delete();
    s = cyc;
    evq.push_back('{s + 3, s + 3 + DIV / 2 + 1,
                    1'b0, 1'b0, 8'h00});
    bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    idle(30);
    chk("glitch_rise", rise_cyc - s, 3);
    chk("glitch_count", ends.size(), 0);
    chk("glitch_data", int'(bus.rx_data), 8'h41);

    ends.delete();
    send(8'h55, 1'b0);
    idle(40);
    chk("ferr_count", ends.size(), 0);
    chk("ferr_data", int'(bus.rx_data), 8'h55);
    send(8'hA5, 1'b1);
    idle(20);
    chk("A5_count", ends.size(), 1);
    if (ends.size() > 0) chk("A5_byte", int'(ends[0]), 8'hA5);

    ends.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h0D, 1'b1);
    idle(20);
    chk("b2b_count", ends.size(), 3);
    if (ends.size() == 3) begin
      chk("b2b_0", int'(ends[0]), 8'h00);
      chk("b2b_1", int'(ends[1]), 8'hFF);
      chk("b2b_2", int'(ends[2]), 8'h0D);
    end

    // Abort mid data bit 4 with an asynchronous reset
    ends.delete();
    pb = 8'hC3;
    s = cyc;
    evq.push_back('{s + 3, s + LAT, 1'b1, 1'b1, pb});
    bus.rx = 1'b0;
    idle(DIV);
    for (int i = 0; i < 4; i++) begin
      bus.rx = pb[i];
      idle(DIV);
    end
    bus.rx = pb[4];
    repeat (DIV / 2) @(posedge clk);
    #3;
    chk("pre_rst_busy", int'(bus.rx_busy), 1);
    rst_n = 1'b0;
    evq.delete();
    base = 8'h00;
    #1;
    chk("arst_busy", int'(bus.rx_busy), 0);
    chk("arst_end", int'(bus.rx_end), 0);
    chk("arst_data", int'(bus.rx_data), 8'h00);
    bus.rx = 1'b1;
    idle(4);
    rst_n = 1'b1;
    idle(5);
    send(8'h3C, 1'b1);
    idle(20);
    chk("3C_count", ends.size(), 1);
    if (ends.size() > 0) chk("3C_byte", int'(ends[0]), 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
